// File: rtl/kiwi_runmon_pkg.sv
// Shared types for the Kiwi run monitor: FSM states and report status codes.
package kiwi_runmon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam logic [1:0] ST_NONE    = 2'd0;
  localparam logic [1:0] ST_OK      = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;

endpackage

// File: rtl/kiwi_runmon_sig.sv
// Rotate-left/XOR accumulator folding the DUT progress word into a
// run signature. Used only when KIWI_RUNMON_SIG_EN is defined.
module kiwi_runmon_sig #(
  parameter int CODE_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [CODE_W-1:0] din,
  output logic [CODE_W-1:0] sig
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= {sig[CODE_W-2:0], sig[CODE_W-1]} ^ din;
    end
  end

endmodule

// File: rtl/kiwi_run_monitor.sv
// Run-length monitor and watchdog for a Kiwi-generated DUT.
// Optional code signature enabled by KIWI_RUNMON_SIG_EN.
module kiwi_run_monitor
  import kiwi_runmon_pkg::*;
#(
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 100000000,
  parameter int CODE_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              dut_done,
  input  logic [CODE_W-1:0] dut_code,
  output logic              run_active,
  output logic              rpt_valid,
  input  logic              rpt_ready,
  output logic [1:0]        rpt_status,
  output logic [CNT_W-1:0]  rpt_cycles,
  output logic [CODE_W-1:0] rpt_sig
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

  state_t           state, state_nxt;
  logic             arm_q;
  logic             start;
  logic [CNT_W-1:0] cnt, cnt_nxt, n;
  logic [1:0]       status_nxt;
  logic [CNT_W-1:0] cycles_nxt;

  assign start      = arm & ~arm_q;
  assign n          = cnt + CNT_W'(1);
  assign run_active = (state == RUN);
  assign rpt_valid  = (state == REPORT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      arm_q      <= 1'b0;
      cnt        <= '0;
      rpt_status <= ST_NONE;
      rpt_cycles <= '0;
    end else begin
      state      <= state_nxt;
      arm_q      <= arm;
      cnt        <= cnt_nxt;
      rpt_status <= status_nxt;
      rpt_cycles <= cycles_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    status_nxt = rpt_status;
    cycles_nxt = rpt_cycles;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        cnt_nxt = n;
        // done beats the watchdog when both land on the same cycle
        if (dut_done) begin
          state_nxt  = REPORT;
          status_nxt = ST_OK;
          cycles_nxt = n;
        end else if (n == TMO) begin
          state_nxt  = REPORT;
          status_nxt = ST_TIMEOUT;
          cycles_nxt = n;
        end
      end
      REPORT: begin
        if (rpt_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef KIWI_RUNMON_SIG_EN
  // sig freezes outside RUN, so it already holds the value latched at REPORT entry
  kiwi_runmon_sig #(
    .CODE_W(CODE_W)
  ) u_sig (
    .clk  (clk),
    .reset(reset),
    .clr  (state == IDLE && start),
    .en   (state == RUN),
    .din  (dut_code),
    .sig  (rpt_sig)
  );
`else
  logic unused_code;
  assign unused_code = ^dut_code;
  assign rpt_sig     = '0;
`endif

endmodule

// File: tb/tb_kiwi_run_monitor.sv
// Randomized self-checking bench for kiwi_run_monitor (CNT_W=8, T=16, CODE_W=8).
module tb_kiwi_run_monitor;

  localparam int CNT_W = 8;
  localparam int TMO   = 16;
  localparam int CW    = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          arm;
  logic          dut_done;
  logic [CW-1:0] dut_code;
  logic          run_active;
  logic          rpt_valid;
  logic          rpt_ready;
  logic [1:0]    rpt_status;
  logic [7:0]    rpt_cycles;
  logic [CW-1:0] rpt_sig;

  int checks   = 0;
  int failures = 0;
  logic [CW-1:0] codes[$];

  kiwi_run_monitor #(
    .CNT_W(CNT_W), .TIMEOUT_CYCLES(TMO), .CODE_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .arm(arm),
    .dut_done(dut_done), .dut_code(dut_code),
    .run_active(run_active), .rpt_valid(rpt_valid),
    .rpt_ready(rpt_ready), .rpt_status(rpt_status),
    .rpt_cycles(rpt_cycles), .rpt_sig(rpt_sig)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] sig_model(input int n);
    logic [CW-1:0] s;
    s = '0;
`ifdef KIWI_RUNMON_SIG_EN
    for (int i = 0; i < n; i++) s = {s[CW-2:0], s[CW-1]} ^ codes[i];
`endif
    return s;
  endfunction

  // One run: done first high on RUN cycle done_at (0 = never).
  task automatic do_run(input string name, input int done_at,
                        input int hold, input bit wiggle, input bit fixed);
    int k;
    int exp_n;
    logic [1:0] exp_st;
    logic [CW-1:0] exp_sig;
    codes.delete();
    if (done_at >= 1 && done_at <= TMO) begin
      exp_n = done_at; exp_st = 2'd1;
    end else begin
      exp_n = TMO; exp_st = 2'd2;
    end
    rpt_ready = 0; dut_done = 0;
    arm = 0; step();
    arm = 1; step();
    if (!wiggle) arm = 0;
    k = 0;
    while (run_active === 1'b1 && k < 40) begin
      k++;
      dut_done = (done_at != 0 && k >= done_at);
      dut_code = fixed ? CW'(1 << (k - 1)) : CW'($urandom);
      codes.push_back(dut_code);
      if (wiggle) arm = 1'($urandom);
      step();
    end
    exp_sig = sig_model(exp_n);
    checks++;
    if (k != exp_n) begin
      failures++;
      $display("FAIL %s run_len: got %0d want %0d", name, k, exp_n);
    end
    checks++;
    if (rpt_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s valid: got %b want 1", name, rpt_valid);
    end
    for (int h = 0; h <= hold; h++) begin
      if (wiggle) arm = 1'($urandom);
      checks++;
      if (rpt_valid !== 1'b1 || rpt_status !== exp_st ||
          rpt_cycles !== 8'(exp_n) || rpt_sig !== exp_sig) begin
        failures++;
        $display("FAIL %s record[%0d]: got v=%b st=%0d cyc=%0d sig=%h want v=1 st=%0d cyc=%0d sig=%h",
                 name, h, rpt_valid, rpt_status, rpt_cycles, rpt_sig,
                 exp_st, exp_n, exp_sig);
      end
      if (h < hold) step();
    end
    rpt_ready = 1;
    if (wiggle) arm = 1;
    step();
    rpt_ready = 0;
    checks++;
    if (rpt_valid !== 1'b0 || run_active !== 1'b0 ||
        rpt_status !== exp_st || rpt_cycles !== 8'(exp_n)) begin
      failures++;
      $display("FAIL %s accept: got v=%b act=%b st=%0d cyc=%0d want v=0 act=0 st=%0d cyc=%0d",
               name, rpt_valid, run_active, rpt_status, rpt_cycles, exp_st, exp_n);
    end
  endtask

  task automatic test_reset();
    reset = 1; arm = 1; dut_done = 1; dut_code = 8'hA5; rpt_ready = 0;
    step(); step();
    checks++;
    if ({run_active, rpt_valid, rpt_status, rpt_cycles, rpt_sig} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got act=%b v=%b st=%0d cyc=%0d sig=%h want all 0",
               run_active, rpt_valid, rpt_status, rpt_cycles, rpt_sig);
    end
    reset = 0;
    step();
    checks++;
    if (run_active !== 1'b1) begin
      failures++;
      $display("FAIL reset_arm_edge: got act=%b want 1", run_active);
    end
    step();
    checks++;
    if (rpt_valid !== 1'b1 || rpt_status !== 2'd1 || rpt_cycles !== 8'd1) begin
      failures++;
      $display("FAIL reset_first_run: got v=%b st=%0d cyc=%0d want v=1 st=1 cyc=1",
               rpt_valid, rpt_status, rpt_cycles);
    end
    rpt_ready = 1; arm = 0; dut_done = 0;
    step();
    rpt_ready = 0;
  endtask

  task automatic test_done7();
    do_run("done7", 7, 5, 0, 0);
  endtask

  task automatic test_timeout();
    do_run("timeout", 0, 1, 0, 0);
    do_run("done_at_limit", TMO, 1, 0, 0);
  endtask

  task automatic test_reset_midrun();
    arm = 0; step();
    arm = 1; step();
    arm = 0;
    step(); step(); step();
    #2 reset = 1;
    #1;
    checks++;
    if ({run_active, rpt_valid, rpt_status, rpt_cycles, rpt_sig} !== '0) begin
      failures++;
      $display("FAIL midrun_reset: got act=%b v=%b st=%0d cyc=%0d sig=%h want all 0",
               run_active, rpt_valid, rpt_status, rpt_cycles, rpt_sig);
    end
    step();
    reset = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (rpt_valid !== 1'b0 || run_active !== 1'b0) begin
        failures++;
        $display("FAIL midrun_quiet[%0d]: got v=%b act=%b want 0 0",
                 i, rpt_valid, run_active);
      end
    end
    do_run("after_reset", 5, 0, 0, 0);
  endtask

  task automatic test_arm_ignored();
    do_run("wiggle_first", 9, 3, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (run_active !== 1'b0) begin
        failures++;
        $display("FAIL lost_edge[%0d]: got act=%b want 0", i, run_active);
      end
    end
    do_run("wiggle_second", 4, 0, 0, 0);
  endtask

  task automatic test_sig();
    do_run("sig_fixed", 3, 0, 0, 1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 12; r++)
      do_run("random", int'($urandom_range(0, 20)),
             int'($urandom_range(0, 3)), 1'($urandom), 0);
  endtask

  initial begin
    test_reset();
    test_done7();
    test_timeout();
    test_reset_midrun();
    test_arm_ignored();
    test_sig();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
